// File: rtl/mem_arbiter_wrr.sv
// mem_arbiter_wrr: weighted round-robin arbiter between N cache-side
// requesters and a single memory port. The arbiter keeps one transaction
// outstanding at a time, registers the request fields on acceptance, and
// routes the memory response back to the requester that owns the port.
module mem_arbiter_wrr #(
  parameter int unsigned N  = 3,
  parameter int unsigned AW = 32,
  parameter int unsigned DW = 32,
  parameter int unsigned WW = 4,
  parameter int unsigned IW = $clog2(N)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N-1:0]      req_valid,
  output logic [N-1:0]      req_ready,
  input  logic [N-1:0]      req_we,
  input  logic [N*AW-1:0]   req_addr,
  input  logic [N*DW-1:0]   req_wdata,
  input  logic [N*WW-1:0]   weight,
  output logic [N-1:0]      rsp_valid,
  output logic [DW-1:0]     rsp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_we,
  output logic [AW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DW-1:0]     mem_rdata,
  output logic              busy,
  output logic [IW-1:0]     owner
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_RSP
  } state_e;

  state_e          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [WW-1:0]   credit_q, credit_d;
  logic [N-1:0]    rsp_valid_q, rsp_valid_d;
  logic [DW-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic            mem_we_q, mem_we_d;
  logic [AW-1:0]   mem_addr_q, mem_addr_d;
  logic [DW-1:0]   mem_wdata_q, mem_wdata_d;

  logic [WW-1:0]   weight_arr [N];
  logic [AW-1:0]   addr_arr   [N];
  logic [DW-1:0]   wdata_arr  [N];

  logic            grant_any;
  logic [IW-1:0]   gnt_idx;
  logic [WW-1:0]   gnt_credit;
  logic [N-1:0]    gnt_onehot;
  logic [N-1:0]    owner_onehot;

  // Unpack the flat per-requester buses into indexable slots.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      weight_arr[i] = weight[i*WW +: WW];
      addr_arr[i]   = req_addr[i*AW +: AW];
      wdata_arr[i]  = req_wdata[i*DW +: DW];
    end
  end

  // Grant selection: the current owner keeps the port while it still has
  // credit; otherwise search owner+1, owner+2, ... with the owner itself last.
  always_comb begin
    logic [IW-1:0] cand;
    int unsigned   own_i;
    grant_any  = 1'b0;
    gnt_idx    = owner_q;
    gnt_credit = '0;
    cand       = '0;
    own_i      = 32'(owner_q);
    if (req_valid[owner_q] && (credit_q < weight_arr[owner_q])) begin
      grant_any  = 1'b1;
      gnt_credit = credit_q + WW'(1);
    end else begin
      for (int unsigned k = 1; k <= N; k++) begin
        cand = IW'((own_i + k) % N);
        if (!grant_any && req_valid[cand]) begin
          grant_any = 1'b1;
          gnt_idx   = cand;
        end
      end
    end
  end

  // One-hot decodes of the selected requester and of the current owner.
  always_comb begin
    gnt_onehot   = '0;
    owner_onehot = '0;
    gnt_onehot[gnt_idx]   = 1'b1;
    owner_onehot[owner_q] = 1'b1;
  end

  // Next-state logic for the IDLE -> ISSUE -> WAIT_RSP transaction sequence.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    credit_d    = credit_q;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_any) begin
          owner_d     = gnt_idx;
          credit_d    = gnt_credit;
          mem_we_d    = req_we[gnt_idx];
          mem_addr_d  = addr_arr[gnt_idx];
          mem_wdata_d = wdata_arr[gnt_idx];
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        // A response arriving in the same cycle as the accept is not honoured.
        if (mem_req_ready) begin
          state_d = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        if (mem_rsp_valid) begin
          rsp_valid_d = owner_onehot;
          rsp_rdata_d = mem_rdata;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and registered-output flops with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      owner_q     <= IW'(N - 1);
      credit_q    <= '0;
      rsp_valid_q <= '0;
      rsp_rdata_q <= '0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      credit_q    <= credit_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end

  // The accept pulse is combinational so a request is taken in the cycle it
  // is arbitrated; it is suppressed while reset is asserted.
  assign req_ready     = (state_q == IDLE && !reset && grant_any) ? gnt_onehot : '0;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_rdata     = rsp_rdata_q;
  assign mem_req_valid = (state_q == ISSUE);
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign busy          = (state_q != IDLE);
  assign owner         = owner_q;

endmodule

// File: tb/tb_mem_arbiter_wrr.sv
// Directed testbench for mem_arbiter_wrr: inputs are driven 1 time unit after
// the rising edge and outputs are sampled 3 units after it.
module tb_mem_arbiter_wrr;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int WW = 4;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N*WW-1:0] weight;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic            mem_req_valid;
  logic            mem_req_ready;
  logic            mem_we;
  logic [AW-1:0]   mem_addr;
  logic [DW-1:0]   mem_wdata;
  logic            mem_rsp_valid;
  logic [DW-1:0]   mem_rdata;
  logic            busy;
  logic [IW-1:0]   owner;

  int n_checks = 0;
  int n_fail   = 0;

  mem_arbiter_wrr #(.N(N), .AW(AW), .DW(DW), .WW(WW)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .weight(weight),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rsp_valid(mem_rsp_valid), .mem_rdata(mem_rdata),
    .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    req_valid     = '0;
    req_we        = '0;
    req_addr      = '0;
    req_wdata     = '0;
    weight        = '0;
    mem_req_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    drive_idle();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Waits (bounded) for an accept pulse; g=-1 on timeout, -2 if not one-hot.
  task automatic wait_grant(input int budget, output int g, output int n,
                            output logic [N-1:0] rsp_seen);
    g = -1;
    n = -1;
    rsp_seen = '0;
    for (int i = 0; i < budget; i++) begin
      #2;
      if (req_ready !== '0) begin
        rsp_seen = rsp_valid;
        case (req_ready)
          3'b001:  g = 0;
          3'b010:  g = 1;
          3'b100:  g = 2;
          default: g = -2;
        endcase
        n = i;
        next_cycle();
        return;
      end
      next_cycle();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    #2;
    n_checks++;
    if ({req_ready, rsp_valid, rsp_rdata, mem_req_valid, mem_we, mem_addr, mem_wdata, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: req_ready=%b rsp_valid=%b rsp_rdata=%h mem_req_valid=%b mem_we=%b mem_addr=%h mem_wdata=%h busy=%b, all expected 0",
               req_ready, rsp_valid, rsp_rdata, mem_req_valid, mem_we, mem_addr, mem_wdata, busy);
    end
    n_checks++;
    if (owner !== 2'd2) begin
      n_fail++;
      $display("FAIL reset_owner: got %0d expected 2", owner);
    end
    next_cycle();
  endtask

  task automatic test_round_robin();
    int g, n;
    logic [N-1:0] rs;
    int exp_g [4] = '{0, 1, 2, 0};
    logic [N-1:0] exp_rs [4] = '{3'b000, 3'b001, 3'b010, 3'b100};
    apply_reset();
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    req_valid     = 3'b111;
    for (int i = 0; i < 4; i++) begin
      wait_grant(10, g, n, rs);
      n_checks++;
      if (g !== exp_g[i]) begin
        n_fail++;
        $display("FAIL rr_grant[%0d]: got %0d expected %0d", i, g, exp_g[i]);
      end
      n_checks++;
      if (rs !== exp_rs[i]) begin
        n_fail++;
        $display("FAIL rr_rsp_with_accept[%0d]: got %b expected %b", i, rs, exp_rs[i]);
      end
      if (i > 0) begin
        n_checks++;
        if (n !== 2) begin
          n_fail++;
          $display("FAIL rr_gap[%0d]: waited %0d cycles expected 2", i, n);
        end
      end
    end
    req_valid = '0;
    repeat (4) next_cycle();
  endtask

  task automatic test_weight();
    int g, n;
    logic [N-1:0] rs;
    int exp_g [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    apply_reset();
    weight        = {4'd0, 4'd0, 4'd2};
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    req_valid     = 3'b011;
    for (int i = 0; i < 8; i++) begin
      wait_grant(10, g, n, rs);
      n_checks++;
      if (g !== exp_g[i]) begin
        n_fail++;
        $display("FAIL weight_grant[%0d]: got %0d expected %0d", i, g, exp_g[i]);
      end
    end
    req_valid = '0;
    repeat (4) next_cycle();
  endtask

  task automatic test_stall();
    int g, n;
    logic [N-1:0] rs;
    apply_reset();
    req_valid = 3'b010;
    req_we    = 3'b000;
    req_addr[1*AW +: AW]  = 32'h40;
    req_wdata[1*DW +: DW] = 32'h0BAD0BAD;
    wait_grant(10, g, n, rs);
    n_checks++;
    if (g !== 1) begin
      n_fail++;
      $display("FAIL stall_grant: got %0d expected 1", g);
    end
    req_valid = '0;
    req_addr  = '0;
    for (int i = 0; i < 3; i++) begin
      #2;
      n_checks++;
      if (mem_req_valid !== 1'b1 || mem_addr !== 32'h40 || mem_we !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_issue_hold[%0d]: mem_req_valid=%b mem_addr=%h mem_we=%b expected 1/00000040/0",
                 i, mem_req_valid, mem_addr, mem_we);
      end
      next_cycle();
    end
    mem_req_ready = 1'b1;
    #2;
    n_checks++;
    if (mem_req_valid !== 1'b1 || mem_addr !== 32'h40) begin
      n_fail++;
      $display("FAIL stall_issue_accept: mem_req_valid=%b mem_addr=%h expected 1/00000040", mem_req_valid, mem_addr);
    end
    next_cycle();
    mem_req_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_checks++;
      if (rsp_valid !== 3'b000 || busy !== 1'b1 || mem_req_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_wait[%0d]: rsp_valid=%b busy=%b mem_req_valid=%b expected 000/1/0",
                 i, rsp_valid, busy, mem_req_valid);
      end
      next_cycle();
    end
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'hDEADBEEF;
    #2;
    n_checks++;
    if (rsp_valid !== 3'b000) begin
      n_fail++;
      $display("FAIL stall_rsp_early: rsp_valid=%b expected 000", rsp_valid);
    end
    next_cycle();
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    #2;
    n_checks++;
    if (rsp_valid !== 3'b010 || rsp_rdata !== 32'hDEADBEEF || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_rsp: rsp_valid=%b rsp_rdata=%h busy=%b expected 010/deadbeef/0", rsp_valid, rsp_rdata, busy);
    end
    next_cycle();
    #2;
    n_checks++;
    if (rsp_valid !== 3'b000 || rsp_rdata !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL stall_rsp_pulse: rsp_valid=%b rsp_rdata=%h expected 000/deadbeef", rsp_valid, rsp_rdata);
    end
    next_cycle();
  endtask

  task automatic test_wrap();
    int g, n;
    logic [N-1:0] rs;
    int exp_g [5] = '{2, 2, 2, 2, 0};
    apply_reset();
    weight        = {4'd3, 4'd0, 4'd0};
    mem_req_ready = 1'b1;
    mem_rsp_valid = 1'b1;
    req_valid     = 3'b100;
    req_we        = 3'b100;
    req_addr[2*AW +: AW]  = 32'h80;
    req_wdata[2*DW +: DW] = 32'h12345678;
    wait_grant(10, g, n, rs);
    n_checks++;
    if (g !== 2) begin
      n_fail++;
      $display("FAIL wrap_first_grant: got %0d expected 2", g);
    end
    req_valid = 3'b001;
    #2;
    n_checks++;
    if (mem_we !== 1'b1 || mem_addr !== 32'h80 || mem_wdata !== 32'h12345678 || owner !== 2'd2) begin
      n_fail++;
      $display("FAIL wrap_write_fields: mem_we=%b mem_addr=%h mem_wdata=%h owner=%0d expected 1/00000080/12345678/2",
               mem_we, mem_addr, mem_wdata, owner);
    end
    next_cycle();
    wait_grant(10, g, n, rs);
    n_checks++;
    if (g !== 0) begin
      n_fail++;
      $display("FAIL wrap_to_zero: got %0d expected 0", g);
    end
    req_valid = 3'b101;
    for (int i = 0; i < 5; i++) begin
      wait_grant(10, g, n, rs);
      n_checks++;
      if (g !== exp_g[i]) begin
        n_fail++;
        $display("FAIL wrap_credit_grant[%0d]: got %0d expected %0d", i, g, exp_g[i]);
      end
    end
    req_valid = '0;
    repeat (4) next_cycle();
  endtask

  task automatic test_reset_mid();
    int g, n;
    logic [N-1:0] rs;
    apply_reset();
    mem_req_ready = 1'b1;
    req_valid     = 3'b001;
    wait_grant(10, g, n, rs);
    n_checks++;
    if (g !== 0) begin
      n_fail++;
      $display("FAIL rmid_grant: got %0d expected 0", g);
    end
    req_valid = '0;
    next_cycle();
    #2;
    n_checks++;
    if (busy !== 1'b1 || mem_req_valid !== 1'b0 || owner !== 2'd0) begin
      n_fail++;
      $display("FAIL rmid_wait_state: busy=%b mem_req_valid=%b owner=%0d expected 1/0/0", busy, mem_req_valid, owner);
    end
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset         = 1'b0;
    mem_rsp_valid = 1'b1;
    mem_rdata     = 32'hA5A5A5A5;
    #2;
    n_checks++;
    if (busy !== 1'b0 || owner !== 2'd2 || rsp_valid !== 3'b000 || mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_after_reset: busy=%b owner=%0d rsp_valid=%b mem_req_valid=%b expected 0/2/000/0",
               busy, owner, rsp_valid, mem_req_valid);
    end
    next_cycle();
    mem_rsp_valid = 1'b0;
    mem_rdata     = '0;
    #2;
    n_checks++;
    if (rsp_valid !== 3'b000 || rsp_rdata !== 32'h0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rmid_late_rsp: rsp_valid=%b rsp_rdata=%h busy=%b expected 000/00000000/0", rsp_valid, rsp_rdata, busy);
    end
    next_cycle();
    req_valid     = 3'b101;
    mem_rsp_valid = 1'b1;
    wait_grant(10, g, n, rs);
    n_checks++;
    if (g !== 0) begin
      n_fail++;
      $display("FAIL rmid_next_grant: got %0d expected 0", g);
    end
    req_valid = '0;
    repeat (4) next_cycle();
  endtask

  task automatic test_spurious();
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      mem_rsp_valid = 1'b1;
      mem_rdata     = 32'hFFFFFFFF;
      #2;
      n_checks++;
      if ({req_ready, rsp_valid, rsp_rdata, mem_req_valid, mem_we, mem_addr, mem_wdata, busy} !== '0 || owner !== 2'd2) begin
        n_fail++;
        $display("FAIL spurious_rsp[%0d]: req_ready=%b rsp_valid=%b rsp_rdata=%h mem_req_valid=%b busy=%b owner=%0d expected zeros, owner 2",
                 i, req_ready, rsp_valid, rsp_rdata, mem_req_valid, busy, owner);
      end
      next_cycle();
    end
    drive_idle();
  endtask

  initial begin
    drive_idle();
    test_reset();
    test_round_robin();
    test_weight();
    test_stall();
    test_wrap();
    test_reset_mid();
    test_spurious();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
